// File: rtl/neg_mac_pkg.sv
// Shared types and helpers for the zero/negligence-gated MAC stage.
package neg_mac_pkg;

    localparam int MAX_W = 128;

    typedef struct packed {
        logic v;
        logic skip;
        logic last;
    } s1_ctrl_t;

    typedef struct packed {
        logic [MAX_W-1:0] max;
        logic [MAX_W-1:0] min;
    } bounds_t;

    // Signed saturation limits for a w-bit value, held in the low w bits.
    function automatic bounds_t sat_bounds(input int w);
        bounds_t b;
        b.max = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
        b.min = ~b.max;
        return b;
    endfunction

endpackage

// File: rtl/neg_gated_mac_sat_add.sv
// Combinational signed saturating adder with overflow indication.
module neg_gated_mac_sat_add
    import neg_mac_pkg::*;
#(
    parameter int W = 40
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam bounds_t BND = sat_bounds(W);

    logic signed [W-1:0] raw;

    // Overflow only when both operands share a sign the wrapped sum lost.
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        if (ovf) begin
            sum = a[W-1] ? BND.min[W-1:0] : BND.max[W-1:0];
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/neg_gated_mac.sv
// Two-stage MAC that skips flagged pairs, saturates the accumulator and
// hands finished sums to drain logic over a valid/ready handshake.
module neg_gated_mac
    import neg_mac_pkg::*;
#(
    parameter int IA_W  = 16,
    parameter int IB_W  = 16,
    parameter int OC_W  = 40,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IA_W-1:0]  i_a,
    input  logic [IB_W-1:0]  i_b,
    input  logic             i_zero_det,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic [OC_W-1:0]  o_res,
    output logic             o_res_sat,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    input  logic             i_cnt_clear,
    output logic [CNT_W-1:0] o_skip_cnt,
    output logic [CNT_W-1:0] o_op_cnt
);

    s1_ctrl_t                    ctrl1;
    logic [IA_W-1:0]             a1;
    logic [IB_W-1:0]             b1;
    logic signed [OC_W-1:0]      acc;
    logic                        sat_acc;
    logic                        stall;
    logic                        accept;
    logic                        consume;
    logic signed [IA_W+IB_W-1:0] prod_raw;
    logic signed [OC_W-1:0]      prod;
    logic signed [OC_W-1:0]      sum;
    logic                        ovf;

    // Only a finished sum blocked by a full output slot can stall the pipe.
    assign stall    = ctrl1.v && ctrl1.last && o_res_valid && !i_res_ready;
    assign o_ready  = !stall;
    assign accept   = i_valid && o_ready;
    assign consume  = ctrl1.v && !stall;
    assign prod_raw = $signed(a1) * $signed(b1);
    assign prod     = ctrl1.skip ? {OC_W{1'b0}} : OC_W'(prod_raw);

    neg_gated_mac_sat_add #(.W(OC_W)) u_sat_add (
        .a   (acc),
        .b   (prod),
        .sum (sum),
        .ovf (ovf)
    );

    // Stage 1: operands only load for unflagged pairs so the multiplier stays quiet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl1 <= s1_ctrl_t'(3'b000);
            a1    <= {IA_W{1'b0}};
            b1    <= {IB_W{1'b0}};
        end else if (!stall) begin
            if (accept) begin
                ctrl1 <= '{v: 1'b1, skip: i_zero_det, last: i_last};
                if (!i_zero_det) begin
                    a1 <= i_a;
                    b1 <= i_b;
                end
            end else begin
                ctrl1.v <= 1'b0;
            end
        end
    end

    // Stage 2: accumulate, and on the last term publish the sum and restart.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc         <= {OC_W{1'b0}};
            sat_acc     <= 1'b0;
            o_res       <= {OC_W{1'b0}};
            o_res_sat   <= 1'b0;
            o_res_valid <= 1'b0;
        end else if (consume && ctrl1.last) begin
            o_res       <= sum;
            o_res_sat   <= sat_acc | ovf;
            o_res_valid <= 1'b1;
            acc         <= {OC_W{1'b0}};
            sat_acc     <= 1'b0;
        end else begin
            if (consume) begin
                acc     <= sum;
                sat_acc <= sat_acc | ovf;
            end
            if (o_res_valid && i_res_ready) begin
                o_res_valid <= 1'b0;
            end
        end
    end

    // Statistics: clear beats increment; both counters stick at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_skip_cnt <= {CNT_W{1'b0}};
            o_op_cnt   <= {CNT_W{1'b0}};
        end else if (i_cnt_clear) begin
            o_skip_cnt <= {CNT_W{1'b0}};
            o_op_cnt   <= {CNT_W{1'b0}};
        end else if (consume) begin
            if (ctrl1.skip) begin
                if (o_skip_cnt != {CNT_W{1'b1}}) begin
                    o_skip_cnt <= o_skip_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                if (o_op_cnt != {CNT_W{1'b1}}) begin
                    o_op_cnt <= o_op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_neg_gated_mac.sv
// Directed self-checking bench for neg_gated_mac (OC_W=32, CNT_W=8).
module tb_neg_gated_mac;

    localparam int IA_W  = 16;
    localparam int IB_W  = 16;
    localparam int OC_W  = 32;
    localparam int CNT_W = 8;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [IA_W-1:0]  i_a;
    logic [IB_W-1:0]  i_b;
    logic             i_zero_det;
    logic             i_valid;
    logic             i_last;
    logic             o_ready;
    logic [OC_W-1:0]  o_res;
    logic             o_res_sat;
    logic             o_res_valid;
    logic             i_res_ready;
    logic             i_cnt_clear;
    logic [CNT_W-1:0] o_skip_cnt;
    logic [CNT_W-1:0] o_op_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    neg_gated_mac #(.IA_W(IA_W), .IB_W(IB_W), .OC_W(OC_W), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_zero_det  (i_zero_det),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_res       (o_res),
        .o_res_sat   (o_res_sat),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .i_cnt_clear (i_cnt_clear),
        .o_skip_cnt  (o_skip_cnt),
        .o_op_cnt    (o_op_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic z, input logic l);
        i_a        = a;
        i_b        = b;
        i_zero_det = z;
        i_last     = l;
        i_valid    = 1'b1;
        @(posedge i_clk); #1;
        i_valid    = 1'b0;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst = 1'b1; i_a = 16'h0000; i_b = 16'h0000; i_zero_det = 1'b0;
        i_valid = 1'b0; i_last = 1'b0; i_res_ready = 1'b1; i_cnt_clear = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 64'(o_ready), 64'h1);
        check("rst_res", 64'(o_res), 64'h0);
        check("rst_valid", 64'(o_res_valid), 64'h0);
        check("rst_skip", 64'(o_skip_cnt), 64'h0);
        check("rst_op", 64'(o_op_cnt), 64'h0);
        i_rst = 1'b0;
        idle();

        // Dense: 12 - 10 - 7 = -5
        send(16'd3, 16'd4, 1'b0, 1'b0);
        send(16'hFFFE, 16'd5, 1'b0, 1'b0);
        send(16'd7, 16'hFFFF, 1'b0, 1'b1);
        idle();
        check("dense_valid", 64'(o_res_valid), 64'h1);
        check("dense_res", 64'(o_res), 64'hFFFF_FFFB);
        check("dense_sat", 64'(o_res_sat), 64'h0);
        check("dense_op", 64'(o_op_cnt), 64'h3);
        check("dense_skip", 64'(o_skip_cnt), 64'h0);
        i_cnt_clear = 1'b1;
        idle();
        i_cnt_clear = 1'b0;
        check("drain_valid", 64'(o_res_valid), 64'h0);
        check("clear_op", 64'(o_op_cnt), 64'h0);

        // Gating: flagged pair leaves operand registers untouched
        send(16'd9, 16'd9, 1'b1, 1'b0);
        check("gate_a1", 64'(dut.a1), 64'h7);
        check("gate_b1", 64'(dut.b1), 64'hFFFF);
        send(16'd2, 16'd3, 1'b0, 1'b1);
        idle();
        check("gate_res", 64'(o_res), 64'h6);
        check("gate_skip", 64'(o_skip_cnt), 64'h1);
        check("gate_op", 64'(o_op_cnt), 64'h1);

        // Saturation then a clean follow-up output
        for (int i = 0; i < 8; i++) begin
            send(16'd32767, 16'd32767, 1'b0, (i == 7));
        end
        idle();
        check("sat_res", 64'(o_res), 64'h7FFF_FFFF);
        check("sat_flag", 64'(o_res_sat), 64'h1);
        send(16'd1, 16'd1, 1'b0, 1'b1);
        idle();
        check("post_sat_res", 64'(o_res), 64'h1);
        check("post_sat_flag", 64'(o_res_sat), 64'h0);

        // Backpressure: second result waits, then replaces the first in one cycle
        idle();
        i_res_ready = 1'b0;
        send(16'd1, 16'd2, 1'b0, 1'b1);
        idle();
        check("bp_first_res", 64'(o_res), 64'h2);
        send(16'd3, 16'd4, 1'b0, 1'b1);
        check("bp_ready_low", 64'(o_ready), 64'h0);
        i_a = 16'd5; i_b = 16'd5; i_zero_det = 1'b0; i_last = 1'b1; i_valid = 1'b1;
        @(posedge i_clk); #1;
        check("bp_hold_a1", 64'(dut.a1), 64'h3);
        check("bp_hold_res", 64'(o_res), 64'h2);
        check("bp_hold_valid", 64'(o_res_valid), 64'h1);
        check("bp_still_low", 64'(o_ready), 64'h0);
        i_valid = 1'b0;
        i_res_ready = 1'b1;
        #1;
        check("bp_ready_high", 64'(o_ready), 64'h1);
        @(posedge i_clk); #1;
        check("bp_second_res", 64'(o_res), 64'hC);
        check("bp_valid_kept", 64'(o_res_valid), 64'h1);
        idle();
        check("bp_drained", 64'(o_res_valid), 64'h0);

        // Counter clear racing a consumed pair, then skip counter saturation
        send(16'd1, 16'd1, 1'b0, 1'b1);
        i_cnt_clear = 1'b1;
        idle();
        i_cnt_clear = 1'b0;
        check("clr_race_op", 64'(o_op_cnt), 64'h0);
        check("clr_race_skip", 64'(o_skip_cnt), 64'h0);
        for (int i = 0; i < 256; i++) begin
            send(16'd0, 16'd0, 1'b1, 1'b0);
        end
        idle();
        check("skip_sat", 64'(o_skip_cnt), 64'hFF);
        send(16'd0, 16'd0, 1'b1, 1'b0);
        send(16'd0, 16'd0, 1'b1, 1'b0);
        idle();
        check("skip_sat_hold", 64'(o_skip_cnt), 64'hFF);
        check("skip_sat_op", 64'(o_op_cnt), 64'h0);

        // Reset mid-accumulation discards the partial sum
        send(16'd1, 16'd1, 1'b0, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_res", 64'(o_res), 64'h0);
        check("mid_rst_valid", 64'(o_res_valid), 64'h0);
        check("mid_rst_skip", 64'(o_skip_cnt), 64'h0);
        check("mid_rst_op", 64'(o_op_cnt), 64'h0);
        check("mid_rst_ready", 64'(o_ready), 64'h1);
        check("mid_rst_a1", 64'(dut.a1), 64'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        send(16'd1, 16'd1, 1'b0, 1'b1);
        idle();
        check("post_rst_res", 64'(o_res), 64'h1);
        check("post_rst_valid", 64'(o_res_valid), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
